xor_rr_scheduler: RTL
=====================

// Module: xor_rr_scheduler
// PURPOSE
//  Shares one registered WIDTH-bit XOR datapath between NREQ requesters.
//  Uses round-robin arbitration with valid/ready handshakes on the request and result sides.
//  Sits in front of the bitwise XOR gate. Serialises operand pairs from several sources
//  and tags each result with the requester id.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=1)
//  NREQ   4  number of requesters (>=2)
//  IDW    $clog2(NREQ)  requester id width (localparam, derived)
// PORTS
//  clk        in   1           single clock, rising edge
//  rst_n      in   1           asynchronous active-low reset
//  req_valid  in   NREQ        requester i has an operand pair pending
//  req_ready  out  NREQ        one-hot grant; pair i accepted when valid[i]&ready[i]
//  a_in       in   NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//  b_in       in   NREQ*WIDTH  operand B, same packing
//  res_valid  out  1           result register holds an undelivered result
//  res_ready  in   1           consumer accepts result this cycle
//  res_data   out  WIDTH       a_in[g] ^ b_in[g] of the served requester g
//  res_id     out  IDW         index g of the served requester
//  ops_count  out  16          only with XOR_SCHED_STATS_EN; accepted-op counter
// BEHAVIOUR
//  - Reset (async, rst_n=0): res_valid=0, res_data=0, res_id=0, ptr=0, ops_count=0.
//    req_ready=0 while rst_n=0. Any pending result is discarded.
//  - State: EMPTY (res_valid=0) / FULL (res_valid=1). can_accept = EMPTY | (FULL & res_ready).
//  - Grant g: first i with req_valid[i]=1, searching ptr, ptr+1, ... wrapping mod NREQ.
//  - req_ready is combinational: req_ready[g]=can_accept; all other bits 0.
//    It is all-zero if no request is pending.
//  - On accept at edge: res_data<=a_in[g]^b_in[g], res_id<=g, res_valid<=1, ptr<=(g+1) mod NREQ.
//    Latency 1 cycle. Throughput 1 op/cycle while res_ready=1.
//  - FULL & res_ready & no accept: res_valid<=0. res_data/res_id keep their last value.
//  - FULL & res_ready & accept (simultaneous drain+load): new result replaces old, res_valid stays 1.
//  - FULL & !res_ready: res_*, ptr frozen; req_ready=0 (backpressure).
//  - ptr does not move without an accept. Idle cycles never change fairness order.
//  - Requesters hold req_valid and operands stable until accepted. No retraction allowed.
//  - res_ready when EMPTY: ignored.
// CONFIGURATION
//  XOR_SCHED_STATS_EN defined: ops_count increments by 1 on every accept and wraps at 16'hFFFF->0.
//  Reset clears it to 0.
//  XOR_SCHED_STATS_EN undefined: ops_count port and counter absent. All other behaviour is identical.
// STRUCTURE
//  - Package xor_sched_pkg: state encoding (ST_EMPTY=1'b0, ST_FULL=1'b1) and default WIDTH/NREQ constants.
//  - Sub-module rr_arbiter: request vector + ptr -> one-hot grant + binary index.
//    Pure combinational.
//  - The top holds the ptr/result registers and the XOR datapath, built from WIDTH bitwise XOR gates.
// TESTING (WIDTH=8, NREQ=4 unless noted)
//  1. rst_n=0 mid-run with res_valid=1 -> same instant: res_valid=0, res_data=0, res_id=0, req_ready=0.
//     After release, next grant starts at requester 0.
//  2. Only req 2 with a=8'hA5, b=8'h0F, res_ready=1 -> req_ready=4'b0100 that cycle.
//     Next cycle: res_valid=1, res_data=8'hAA, res_id=2.
//  3. All 4 req_valid held, res_ready=1 -> res_id sequence 0,1,2,3,0 on consecutive cycles.
//     No requester is skipped.
//  4. Result FULL, res_ready=0 for 3 cycles -> req_ready=0, res_data/res_id stable.
//     Raise res_ready -> drain and new accept in the same cycle, res_valid stays 1.
//  5. WIDTH=1, one requester, pairs 00,01,10,11 -> res_data 0,1,1,0.
//  6. XOR_SCHED_STATS_EN: 5 accepts -> ops_count=5. Reset -> 0.
//     Preloaded to 16'hFFFF, one accept -> 0.

Source files
------------

// File: rtl/xor_sched_pkg.sv
// Shared types and default sizing for the round-robin XOR scheduler.
// Build option: XOR_SCHED_STATS_EN adds a 16-bit accepted-operation counter.
package xor_sched_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_NREQ  = 4;
  localparam int unsigned CNT_W     = 16;

endpackage

// File: rtl/xor_rr_scheduler_if.sv
// Request/result handshake bundle between requesters, scheduler and result consumer.
// Build option: XOR_SCHED_STATS_EN adds ops_count to the bundle.
interface xor_rr_scheduler_if
  import xor_sched_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NREQ  = DEF_NREQ
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] a_in;
  logic [NREQ*WIDTH-1:0] b_in;
  logic                  res_valid;
  logic                  res_ready;
  logic [WIDTH-1:0]      res_data;
  logic [IDW-1:0]        res_id;
`ifdef XOR_SCHED_STATS_EN
  logic [CNT_W-1:0]      ops_count;

  modport master (
    output req_valid, a_in, b_in, res_ready,
    input  req_ready, res_valid, res_data, res_id, ops_count
  );
  modport slave (
    input  req_valid, a_in, b_in, res_ready,
    output req_ready, res_valid, res_data, res_id, ops_count
  );
`else
  modport master (
    output req_valid, a_in, b_in, res_ready,
    input  req_ready, res_valid, res_data, res_id
  );
  modport slave (
    input  req_valid, a_in, b_in, res_ready,
    output req_ready, res_valid, res_data, res_id
  );
`endif

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after i_ptr, wrapping.
module rr_arbiter
  import xor_sched_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  logic [IDW-1:0] w_idx;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_idx = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      w_idx = IDW'((32'(i_ptr) + off) % NREQ);
      if (!o_any && i_req[w_idx]) begin
        o_any        = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_idx        = w_idx;
      end
    end
  end

endmodule

// File: rtl/xor_rr_scheduler.sv
// Round-robin scheduler sharing one registered XOR datapath among NREQ requesters.
// Build option: XOR_SCHED_STATS_EN enables the ops_count accepted-operation counter.
module xor_rr_scheduler
  import xor_sched_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NREQ  = DEF_NREQ
) (
  input  logic              clk,
  input  logic              rst_n,
  xor_rr_scheduler_if.slave bus
);

  localparam int unsigned IDW = $clog2(NREQ);

  state_e           r_state;
  logic [WIDTH-1:0] r_data;
  logic [IDW-1:0]   r_id;
  logic [IDW-1:0]   r_ptr;

  logic [NREQ-1:0]  w_gnt;
  logic [IDW-1:0]   w_idx;
  logic             w_any;
  logic             w_can_accept;
  logic             w_accept;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_xor;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req (bus.req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // A slot frees up when empty or when the held result drains this cycle.
  assign w_can_accept = (r_state == ST_EMPTY) || bus.res_ready;
  assign w_accept     = w_any && w_can_accept;
  assign bus.req_ready = w_gnt & {NREQ{w_can_accept & rst_n}};

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_a = bus.a_in[i*WIDTH +: WIDTH];
        w_b = bus.b_in[i*WIDTH +: WIDTH];
      end
    end
  end

  for (genvar gb = 0; gb < WIDTH; gb++) begin : g_xor
    assign w_xor[gb] = w_a[gb] ^ w_b[gb];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
      r_id    <= '0;
      r_ptr   <= '0;
    end else if (w_accept) begin
      r_state <= ST_FULL;
      r_data  <= w_xor;
      r_id    <= w_idx;
      r_ptr   <= IDW'((32'(w_idx) + 32'd1) % NREQ);
    end else if ((r_state == ST_FULL) && bus.res_ready) begin
      r_state <= ST_EMPTY;
    end
  end

  assign bus.res_valid = (r_state == ST_FULL);
  assign bus.res_data  = r_data;
  assign bus.res_id    = r_id;

`ifdef XOR_SCHED_STATS_EN
  logic [CNT_W-1:0] r_ops;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_ops <= '0;
    else if (w_accept) r_ops <= r_ops + CNT_W'(1);
  end

  assign bus.ops_count = r_ops;
`endif

endmodule
